// File: rtl/sine_ctrl_saxi.sv
// AXI4-Lite slave holding the four 32-bit control words for the sine core.
// Optional feature: define SINE_CTRL_SAXI_SLVERR_EN to answer out-of-range addresses with SLVERR.
module sine_ctrl_saxi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic {StWIdle, StWResp} wstate_e;
    typedef enum logic {StRIdle, StRData} rstate_e;

    wstate_e        wstate_q;
    rstate_e        rstate_q;
    logic [DW-1:0]  regs_q [4];
    logic           aw_held_q, w_held_q;
    logic [AW-1:0]  aw_addr_q;
    logic [DW-1:0]  w_data_q;
    logic [SW-1:0]  w_strb_q;
    logic           awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]     bresp_q, rresp_q;
    logic [DW-1:0]  rdata_q;

    logic           aw_hs, w_hs, aw_have, w_have, wr_err, rd_err;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [SW-1:0]  wr_strb;

    // A channel counts as present if captured earlier or handshaking on this edge.
    assign aw_hs   = S_AXI_AWVALID && awready_q;
    assign w_hs    = S_AXI_WVALID && wready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;
    assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    assign wr_data = w_hs ? S_AXI_WDATA : w_data_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_q;

`ifdef SINE_CTRL_SAXI_SLVERR_EN
    assign wr_err = |wr_addr[AW-1:4];
    assign rd_err = |S_AXI_ARADDR[AW-1:4];
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], wr_addr[AW-1:4],
                           S_AXI_ARADDR[1:0], S_AXI_ARADDR[AW-1:4]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q  <= StWIdle;
            regs_q    <= '{default: '0};
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            unique case (wstate_q)
                StWIdle: begin
                    if (aw_have && w_have) begin
                        if (!wr_err) begin
                            for (int b = 0; b < SW; b++) begin
                                if (wr_strb[b]) regs_q[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
                            end
                        end
                        bresp_q   <= wr_err ? RespSlvErr : RespOkay;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        wstate_q  <= StWResp;
                    end else begin
                        aw_held_q <= aw_have;
                        w_held_q  <= w_have;
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                        if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
                        if (w_hs) begin
                            w_data_q <= S_AXI_WDATA;
                            w_strb_q <= S_AXI_WSTRB;
                        end
                    end
                end
                StWResp: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= StWIdle;
                    end
                end
            endcase
        end
    end

    // Nonblocking semantics give a same-edge read the pre-write register value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q  <= StRIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            unique case (rstate_q)
                StRIdle: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        rdata_q   <= rd_err ? '0 : regs_q[S_AXI_ARADDR[3:2]];
                        rresp_q   <= rd_err ? RespSlvErr : RespOkay;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= StRData;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                StRData: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= StRIdle;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign ctrl_reg0     = regs_q[0];
    assign ctrl_reg1     = regs_q[1];
    assign ctrl_reg2     = regs_q[2];
    assign ctrl_reg3     = regs_q[3];

endmodule

// File: tb/tb_sine_ctrl_saxi.sv
// Self-checking bench for sine_ctrl_saxi: vector table, directed handshake corners, random traffic.
// Honours SINE_CTRL_SAXI_SLVERR_EN when the design is built with it.
module tb_sine_ctrl_saxi;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESET = 1'b1;
    logic [5:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA, ctrl_reg0, ctrl_reg1, ctrl_reg2, ctrl_reg3;

    always #5 tb_ACLK = ~tb_ACLK;

    sine_ctrl_saxi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl_reg0(ctrl_reg0), .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3)
    );

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] mdl [4];

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    function automatic bit model_err(input logic [5:0] a);
`ifdef SINE_CTRL_SAXI_SLVERR_EN
        return a >= 6'd16;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [5:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        int idx;
        logic [31:0] m;
        if (model_err(a)) return;
        idx = (int'(a) / 4) % 4;
        for (int b = 0; b < 4; b++) begin
            m = 32'hFF << (8 * b);
            if (s[b]) mdl[idx] = (mdl[idx] & ~m) | (d & m);
        end
    endfunction

    function automatic logic [31:0] ctrl(input int i);
        case (i)
            0: return ctrl_reg0;
            1: return ctrl_reg1;
            2: return ctrl_reg2;
            default: return ctrl_reg3;
        endcase
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit awd, wd;
        int n;
        @(negedge tb_ACLK);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        awd = 0; wd = 0; n = 0;
        while (!(awd && wd) && n < 20) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) awd = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) wd = 1;
            @(negedge tb_ACLK);
            n++;
            if (awd) S_AXI_AWVALID = 0;
            if (wd) S_AXI_WVALID = 0;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 20) timeout("write_bvalid");
        resp = S_AXI_BRESP;
        @(negedge tb_ACLK);
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge tb_ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 20) timeout("read_rvalid");
        d = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(negedge tb_ACLK);
        S_AXI_RREADY = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0] = '{6'h00, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
        vecs[1] = '{6'h04, 32'hABCD0001, 4'hF, 32'hABCD0001};
        vecs[2] = '{6'h08, 32'hDEAD0011, 4'hF, 32'hDEAD0011};
        vecs[3] = '{6'h0C, 32'hBEEF0011, 4'hF, 32'hBEEF0011};
        vecs[4] = '{6'h04, 32'h12345678, 4'hF, 32'h12345678};
        vecs[5] = '{6'h05, 32'hFFFFFFFF, 4'b0010, 32'h1234FF78};
        for (int i = 0; i < 4; i++) mdl[i] = '0;

        // Reset state
        repeat (3) @(negedge tb_ACLK);
        check("rst_awready", 32'(S_AXI_AWREADY), 0);
        check("rst_wready", 32'(S_AXI_WREADY), 0);
        check("rst_arready", 32'(S_AXI_ARREADY), 0);
        check("rst_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 0);
        check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_regs", ctrl_reg0 | ctrl_reg1 | ctrl_reg2 | ctrl_reg3, 0);
        tb_ARESET = 0;
        @(negedge tb_ACLK);
        check("post_rst_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

        // Vector table: write, read back, compare data, responses and the control port
        for (int i = 0; i < 6; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            check("tbl_bresp", 32'(rsp), 0);
            axi_read(vecs[i].addr, rd, rsp);
            check("tbl_rdata", rd, vecs[i].exp);
            check("tbl_rresp", 32'(rsp), 0);
            check("tbl_ctrl", ctrl(int'(vecs[i].addr[3:2])), vecs[i].exp);
        end
        check("tbl_reg0", ctrl_reg0, 32'h0101FFFF);
        check("tbl_reg2", ctrl_reg2, 32'hDEAD0011);
        check("tbl_reg3", ctrl_reg3, 32'hBEEF0011);

        // W arrives three cycles ahead of AW
        @(negedge tb_ACLK);
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h0C0C0C0C; S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        @(negedge tb_ACLK);
        S_AXI_WVALID = 0;
        check("wfirst_wready", 32'(S_AXI_WREADY), 0);
        check("wfirst_awready", 32'(S_AXI_AWREADY), 1);
        repeat (2) begin
            @(negedge tb_ACLK);
            check("wfirst_no_bvalid", 32'(S_AXI_BVALID), 0);
        end
        S_AXI_AWVALID = 1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 0;
        model_write(6'h0C, 32'h0C0C0C0C, 4'hF);
        check("wfirst_bvalid", 32'(S_AXI_BVALID), 1);
        check("wfirst_reg3", ctrl_reg3, mdl[3]);
        S_AXI_BREADY = 1;
        @(negedge tb_ACLK);
        S_AXI_BREADY = 0;
        check("wfirst_bdone", 32'(S_AXI_BVALID), 0);
        check("wfirst_ready_back", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h3);
        @(negedge tb_ACLK);
        check("wfirst_single", 32'(S_AXI_BVALID), 0);

        // BREADY held low for 5 cycles
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = 32'h77665544; S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        model_write(6'h0C, 32'h77665544, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid", 32'(S_AXI_BVALID), 1);
            check("bhold_bresp", 32'(S_AXI_BRESP), 0);
            check("bhold_readys", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 0);
            @(negedge tb_ACLK);
        end
        S_AXI_BREADY = 1;
        @(negedge tb_ACLK);
        S_AXI_BREADY = 0;
        check("bhold_release", 32'(S_AXI_BVALID), 0);

        // RREADY held low for 5 cycles
        S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid", 32'(S_AXI_RVALID), 1);
            check("rhold_rdata", S_AXI_RDATA, mdl[3]);
            check("rhold_rresp", 32'(S_AXI_RRESP), 0);
            check("rhold_arready", 32'(S_AXI_ARREADY), 0);
            @(negedge tb_ACLK);
        end
        S_AXI_RREADY = 1;
        @(negedge tb_ACLK);
        S_AXI_RREADY = 0;
        check("rhold_release", {30'd0, S_AXI_RVALID, S_AXI_ARREADY}, 32'h1);

        // Read and write of 0x8 on the same edge
        S_AXI_AWADDR = 6'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        check("same_edge_rdata", S_AXI_RDATA, 32'hDEAD0011);
        check("same_edge_reg2", ctrl_reg2, 32'h00000055);
        model_write(6'h08, 32'h55, 4'hF);
        S_AXI_RREADY = 1;
        @(negedge tb_ACLK);
        S_AXI_RREADY = 0; S_AXI_BREADY = 0;
        axi_read(6'h08, rd, rsp);
        check("same_edge_later", rd, 32'h00000055);

        // Address beyond the 16-byte window
        axi_write(6'h10, 32'hA5A5A5A5, 4'hF, rsp);
        model_write(6'h10, 32'hA5A5A5A5, 4'hF);
        check("oor_bresp", 32'(rsp), model_err(6'h10) ? 32'h2 : 32'h0);
        check("oor_reg0", ctrl_reg0, mdl[0]);
        axi_read(6'h10, rd, rsp);
        check("oor_rdata", rd, model_err(6'h10) ? 32'h0 : mdl[0]);
        check("oor_rresp", 32'(rsp), model_err(6'h10) ? 32'h2 : 32'h0);

        // Reset while BVALID is high
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'h1; S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        check("rstmid_bvalid", 32'(S_AXI_BVALID), 1);
        tb_ARESET = 1;
        @(negedge tb_ACLK);
        check("rstmid_bvalid_gone", 32'(S_AXI_BVALID), 0);
        check("rstmid_awready", 32'(S_AXI_AWREADY), 0);
        check("rstmid_regs", ctrl_reg0 | ctrl_reg1 | ctrl_reg2 | ctrl_reg3, 0);
        tb_ARESET = 0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        @(negedge tb_ACLK);
        check("rstmid_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        check("rstmid_no_bvalid", 32'(S_AXI_BVALID), 0);

        // Random traffic against the byte-merge model
        for (int i = 0; i < 300; i++) begin
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, rsp);
                model_write(a, d, s);
                check("rnd_bresp", 32'(rsp), model_err(a) ? 32'h2 : 32'h0);
                for (int r = 0; r < 4; r++) check("rnd_ctrl", ctrl(r), mdl[r]);
            end else begin
                axi_read(a, rd, rsp);
                check("rnd_rdata", rd, model_err(a) ? 32'h0 : mdl[(int'(a) / 4) % 4]);
                check("rnd_rresp", 32'(rsp), model_err(a) ? 32'h2 : 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_ctrl_saxi.md
SINE_CTRL_SAXI -- requirements
Module: sine_ctrl_saxi

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width (16-word window).
REQ-003 SHALL use one clock and a synchronous, active-high reset:
  - ACLK  in  1  clock.
  - ARESET  in  1  synchronous reset, active-high.
REQ-004 SHALL have the write address channel:
  - S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address.
  - S_AXI_AWPROT  in  3  ignored.
  - S_AXI_AWVALID  in  1.
  - S_AXI_AWREADY  out  1.
REQ-005 SHALL have the write data channel:
  - S_AXI_WDATA  in  32.
  - S_AXI_WSTRB  in  4  byte enables.
  - S_AXI_WVALID  in  1.
  - S_AXI_WREADY  out  1.
REQ-006 SHALL have the write response channel:
  - S_AXI_BRESP  out  2.
  - S_AXI_BVALID  out  1.
  - S_AXI_BREADY  in  1.
REQ-007 SHALL have the read address channel:
  - S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH.
  - S_AXI_ARPROT  in  3  ignored.
  - S_AXI_ARVALID  in  1.
  - S_AXI_ARREADY  out  1.
REQ-008 SHALL have the read data channel:
  - S_AXI_RDATA  out  32.
  - S_AXI_RRESP  out  2.
  - S_AXI_RVALID  out  1.
  - S_AXI_RREADY  in  1.
REQ-009 SHALL drive the register outputs ctrl_reg0..ctrl_reg3, out, 32 each, current contents of registers at byte offsets 0x0/0x4/0x8/0xC, to the sine core.

Function
REQ-010 SHALL decode the word index from ADDR[3:2]; ADDR[1:0] ignored.
REQ-011 SHALL run the write path as FSM W_IDLE -> W_RESP -> W_IDLE.
REQ-012 SHALL capture AW and W independently in W_IDLE: AWREADY=1 until the AW handshake, then 0; WREADY=1 until the W handshake, then 0; either order or the same cycle.
REQ-013 SHALL commit the write on the edge where both AW and W are held; each byte i updates only if WSTRB[i]=1; BVALID rises the next cycle (W_RESP).
REQ-014 SHALL hold BVALID and BRESP stable until BREADY=1; on the handshake edge return to W_IDLE with AWREADY=WREADY=1 the next cycle.
REQ-015 SHALL accept no new AW or W while in W_RESP.
REQ-016 SHALL run the read path as FSM R_IDLE -> R_DATA -> R_IDLE.
REQ-017 SHALL assert ARREADY=1 in R_IDLE; on the AR handshake, RDATA and RRESP are registered and RVALID=1 the next cycle; ARREADY=0 in R_DATA.
REQ-018 SHALL hold RDATA, RRESP and RVALID stable until RREADY=1, then return to R_IDLE.
REQ-019 SHALL resolve a read handshake and a write commit to the same register on the same edge so that the read returns the pre-write value.
REQ-020 SHALL run the read and write paths concurrently without mutual stalling.
REQ-021 SHALL have BRESP and RRESP = OKAY (2'b00) except as in REQ-025.
REQ-022 SHALL change ctrl_regN only on the commit edge; zero additional latency.

Reset
REQ-023 SHALL, while ARESET=1 at a rising ACLK, have:
  - all four registers = 0.
  - both FSMs idle, with held AW/W flags cleared.
  - AWREADY = WREADY = ARREADY = 0.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
REQ-024 SHALL drop any transaction in flight when reset is asserted mid-transaction, with no response issued; READYs rise on the first edge after ARESET deasserts.

Configuration
REQ-025 SHALL implement macro SINE_CTRL_SAXI_SLVERR_EN:
  - Defined: an address with any bit above [3:2] nonzero is out-of-range. A write there modifies no register and responds BRESP=SLVERR (2'b10); a read there returns RDATA=0 with RRESP=SLVERR.
  - Undefined: the upper bits are ignored, addresses alias modulo 16 bytes, and the response is always OKAY.

Verification
REQ-026 SHALL cover the following directed scenarios:
  - Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0/0x4/0x8/0xC, reading back after each -> readback equals written data, all resp OKAY, ctrl_reg0..3 match.
  - W presented 3 cycles before AW, then AW presented alone -> exactly one write, BVALID one cycle after the AW handshake.
  - Write 0x12345678 to 0x4, then WSTRB=4'b0010 with 0xFFFFFFFF -> readback 0x1234FF78.
  - BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY=0 throughout; same check for RREADY/RVALID.
  - Read of 0x8 on the same edge as a write of 0x55 to 0x8 (old value 0xDEAD0011) -> RDATA=0xDEAD0011, then a later read returns 0x00000055.
  - Write to 0x10:
    - SLVERR_EN defined: BRESP=2'b10 and reg0 unchanged.
    - Undefined: reg0 written, OKAY.
    - Either case: reset asserted with BVALID=1 -> BVALID=0 next edge.
